// File: rtl/io_ctrl_pkg.sv
// Shared types for the IN/OUT handshake controller: FSM state and pending-operation encodings.
package io_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    OP_IN  = 1'b0,
    OP_OUT = 1'b1
  } op_e;

endpackage

// File: rtl/enter_debouncer.sv
// Enter key conditioning: 2-flop synchronizer, stability counter, filtered level and 1-cycle edge pulses.
module enter_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the filtered level;
  // the sample that completes the run flips the level and raises the matching edge pulse.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync_q[1];
        press_d   = sync_q[1];
        release_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/io_handshake_ctrl.sv
// IN/OUT instruction sequencer: stalls the processor until the operator confirms with a debounced
// enter press and release; IN captures the switch word, OUT loads the display register.
module io_handshake_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W          = 18,
  parameter int unsigned OUT_W           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
  input  logic              out,
  input  logic              enter,
  input  logic [DATA_W-1:0] entrada,
  input  logic [OUT_W-1:0]  dado_saida,
  output logic              sinal,
  output logic [DATA_W-1:0] valor,
  output logic [OUT_W-1:0]  display,
  output logic              done
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              sinal_q, sinal_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] valor_q, valor_d;
  logic [OUT_W-1:0]  display_q, display_d;

  logic key_level, key_press, key_release;
  logic request, accept;

  enter_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .raw_i    (enter),
    .level_o  (key_level),
    .press_o  (key_press),
    .release_o(key_release)
  );

  // A request is only accepted once the key is seen released, so a press left over from
  // the previous operation cannot confirm the new one.
  assign request = in | out;
  assign accept  = request & ~key_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_IN;
      sinal_q   <= 1'b0;
      done_q    <= 1'b0;
      valor_q   <= '0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sinal_q   <= sinal_d;
      done_q    <= done_d;
      valor_q   <= valor_d;
      display_q <= display_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in ? OP_IN : OP_OUT;
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (key_press) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (key_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sinal_d   = 1'b0;
    done_d    = 1'b0;
    valor_d   = valor_q;
    display_d = display_q;
    unique case (state_q)
      IDLE: begin
        sinal_d = request;
        if (accept && !in) display_d = dado_saida;
      end
      WAIT_PRESS: begin
        sinal_d = 1'b1;
        if (key_press && op_q == OP_IN) valor_d = entrada;
      end
      WAIT_RELEASE: begin
        sinal_d = ~key_release;
        done_d  = key_release;
      end
      default: ;
    endcase
  end

  assign sinal   = sinal_q;
  assign done    = done_q;
  assign valor   = valor_q;
  assign display = display_q;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Directed bench for io_handshake_ctrl with DEBOUNCE_CYCLES=4 (raw enter -> press in 6 cycles).
module tb_io_handshake_ctrl;
  import io_ctrl_pkg::*;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned OUT_W  = 18;

  logic              clock = 1'b0;
  logic              reset;
  logic              in, out, enter;
  logic [DATA_W-1:0] entrada;
  logic [OUT_W-1:0]  dado_saida;
  logic              sinal, done;
  logic [DATA_W-1:0] valor;
  logic [OUT_W-1:0]  display;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  io_handshake_ctrl #(
    .DATA_W(DATA_W),
    .OUT_W(OUT_W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .in(in), .out(out), .enter(enter),
    .entrada(entrada), .dado_saida(dado_saida),
    .sinal(sinal), .valor(valor), .display(display), .done(done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_sinal_at_done"}, 32'(sinal), 32'd0);
  endtask

  task automatic key_pulse(input int hold);
    enter = 1'b1;
    tick(hold);
    enter = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; out = 1'b0; enter = 1'b0;
    entrada = '0; dado_saida = '0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Reset in the middle of an IN that has already captured
    entrada = 18'h1F0F0; in = 1'b1;
    tick(1);
    enter = 1'b1;
    tick(8);
    chk("t1_pre_valor", 32'(valor), 32'h1F0F0);
    reset = 1'b1;
    tick(3);
    chk("t1_sinal", 32'(sinal), 32'd0);
    chk("t1_valor", 32'(valor), 32'd0);
    chk("t1_display", 32'(display), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_state", 32'(dut.state_q), 32'(IDLE));
    in = 1'b0; enter = 1'b0; reset = 1'b0;
    tick(8);
    chk("t1_no_done", 32'(done_cnt), 32'd0);

    // IN with a clean 10-cycle enter pulse
    entrada = 18'h2A5A5; in = 1'b1;
    tick(1);
    chk("t2_sinal_accept", 32'(sinal), 32'd1);
    chk("t2_state", 32'(dut.state_q), 32'(WAIT_PRESS));
    enter = 1'b1;
    tick(6);
    chk("t2_valor_pre", 32'(valor), 32'd0);
    tick(1);
    chk("t2_valor", 32'(valor), 32'h2A5A5);
    tick(3);
    enter = 1'b0;
    tick(6);
    chk("t2_done_early", 32'(done), 32'd0);
    chk("t2_sinal_hold", 32'(sinal), 32'd1);
    tick(1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_sinal_done", 32'(sinal), 32'd0);
    in = 1'b0;
    tick(1);
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // OUT loads display one cycle after accept, valor untouched
    dado_saida = 18'h00123; out = 1'b1;
    tick(1);
    chk("t3_display", 32'(display), 32'h00123);
    chk("t3_sinal", 32'(sinal), 32'd1);
    key_pulse(10);
    wait_done(12, "t3");
    out = 1'b0;
    tick(1);
    chk("t3_valor", 32'(valor), 32'h2A5A5);
    chk("t3_done_cnt", 32'(done_cnt), 32'd2);

    // Bouncing key: no press until it settles, then exactly one capture
    entrada = 18'h15555; in = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      enter = (i % 2 == 0);
      tick(2);
    end
    chk("t4_no_capture", 32'(valor), 32'h2A5A5);
    chk("t4_still_wait", 32'(dut.state_q), 32'(WAIT_PRESS));
    chk("t4_no_done", 32'(done_cnt), 32'd2);
    key_pulse(10);
    wait_done(12, "t4");
    in = 1'b0;
    tick(1);
    chk("t4_valor", 32'(valor), 32'h15555);
    chk("t4_done_cnt", 32'(done_cnt), 32'd3);

    // in=out=1 with the key held at request time
    enter = 1'b1;
    tick(8);
    entrada = 18'h3FFFF; dado_saida = 18'h0AAAA; in = 1'b1; out = 1'b1;
    tick(1);
    chk("t5_sinal_stall", 32'(sinal), 32'd1);
    chk("t5_state_held", 32'(dut.state_q), 32'(IDLE));
    tick(4);
    chk("t5_state_held2", 32'(dut.state_q), 32'(IDLE));
    enter = 1'b0;
    tick(6);
    chk("t5_state_pre", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    chk("t5_state_accept", 32'(dut.state_q), 32'(WAIT_PRESS));
    key_pulse(10);
    wait_done(12, "t5");
    in = 1'b0; out = 1'b0;
    tick(1);
    chk("t5_valor", 32'(valor), 32'h3FFFF);
    chk("t5_display", 32'(display), 32'h00123);
    chk("t5_done_cnt", 32'(done_cnt), 32'd4);

    // Entrada changes after press; back-to-back request
    entrada = 18'h11111; in = 1'b1;
    tick(1);
    enter = 1'b1;
    tick(7);
    chk("t6_valor_press", 32'(valor), 32'h11111);
    entrada = 18'h22222;
    tick(3);
    enter = 1'b0;
    wait_done(12, "t6a");
    chk("t6_valor_kept", 32'(valor), 32'h11111);
    tick(1);
    chk("t6_b2b_state", 32'(dut.state_q), 32'(WAIT_PRESS));
    chk("t6_b2b_sinal", 32'(sinal), 32'd1);
    chk("t6_b2b_done", 32'(done), 32'd0);
    key_pulse(10);
    wait_done(12, "t6b");
    in = 1'b0;
    tick(1);
    chk("t6_valor2", 32'(valor), 32'h22222);
    chk("t6_done_cnt", 32'(done_cnt), 32'd6);
    chk("t6_sinal_idle", 32'(sinal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
